// File: rtl/display_7seg_mux_if.sv
// display_7seg_mux_if: digit data/control in, segment and digit-select pins out
//   valores     : 4 bits per digit, digit 0 in the low nibble
//   modo_hex    : show A..F for values 10..15 instead of blanking them
//   apaga_zeros : blank leading zeros (digit 0 always shown)
//   pisca       : per-digit blink mask
//   habilita    : 0 freezes the scan and turns the display off
//   segmentos   : active-low segments, bit0=A .. bit6=G
//   digito_sel  : active-low one-hot digit select
interface display_7seg_mux_if #(
    parameter int NUM_DIGITOS = 6
);
    logic [4*NUM_DIGITOS-1:0] valores;
    logic                     modo_hex;
    logic                     apaga_zeros;
    logic [NUM_DIGITOS-1:0]   pisca;
    logic                     habilita;
    logic [6:0]               segmentos;
    logic [NUM_DIGITOS-1:0]   digito_sel;

    modport master (
        output valores, modo_hex, apaga_zeros, pisca, habilita,
        input  segmentos, digito_sel
    );

    modport slave (
        input  valores, modo_hex, apaga_zeros, pisca, habilita,
        output segmentos, digito_sel
    );
endinterface

// File: rtl/display_7seg_mux.sv
// display_7seg_mux: time-multiplexed N-digit common-anode 7-segment driver
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of display_7seg_mux_if (digit values/controls in, pins out)
// Scans one digit per DIV_VARREDURA cycles with one dark cycle between digits,
// decodes BCD/hex, blanks leading zeros and blinks masked digits. Inputs are
// captured into shadow registers only at frame boundaries.
module display_7seg_mux #(
    parameter int NUM_DIGITOS   = 6,
    parameter int DIV_VARREDURA = 50000,
    parameter int DIV_PISCA     = 64
) (
    input logic              clk,
    input logic              rst_n,
    display_7seg_mux_if.slave bus
);
    localparam int N  = NUM_DIGITOS;
    localparam int IW = N > 1 ? $clog2(N) : 1;
    localparam int CW = $clog2(DIV_VARREDURA);
    localparam int FW = DIV_PISCA > 1 ? $clog2(DIV_PISCA) : 1;
    localparam logic [6:0] APAGADO = 7'b1111111;
    localparam logic [6:0] TABELA [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic [CW-1:0]  cnt_div;
    logic [IW-1:0]  idx;
    logic [FW-1:0]  cnt_frame;
    logic           fase;
    logic           carregado;
    logic [4*N-1:0] sh_valores;
    logic [N-1:0]   sh_pisca;
    logic           sh_hex;
    logic           sh_apaga;

    logic           tick;
    logic           fim_quadro;
    logic [N-1:0]   zero_topo;
    logic           topo;
    logic [3:0]     dig;
    logic           pisca_at;
    logic           zero_at;
    logic           apagado;
    logic [6:0]     seg_dec;

    always_comb begin
        tick       = bus.habilita && cnt_div == CW'(DIV_VARREDURA - 1);
        fim_quadro = tick && idx == IW'(N - 1);
        // zero_topo[i]: digit i and every digit above it are zero
        topo      = 1'b1;
        zero_topo = '0;
        for (int i = N - 1; i >= 0; i--) begin
            topo         = topo && sh_valores[4*i +: 4] == 4'd0;
            zero_topo[i] = topo;
        end
        dig      = 4'(sh_valores >> {idx, 2'b00});
        pisca_at = 1'(sh_pisca >> idx);
        zero_at  = 1'(zero_topo >> idx);
        apagado  = (pisca_at && fase) || (sh_apaga && idx != '0 && zero_at);
        seg_dec  = (!sh_hex && dig > 4'd9) ? APAGADO : TABELA[dig];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_div        <= '0;
            idx            <= '0;
            cnt_frame      <= '0;
            fase           <= 1'b0;
            carregado      <= 1'b0;
            sh_valores     <= '0;
            sh_pisca       <= '0;
            sh_hex         <= 1'b0;
            sh_apaga       <= 1'b0;
            bus.segmentos  <= APAGADO;
            bus.digito_sel <= '1;
        end else begin
            // first edge out of reset, then once per frame wrap
            if (!carregado || fim_quadro) begin
                sh_valores <= bus.valores;
                sh_pisca   <= bus.pisca;
                sh_hex     <= bus.modo_hex;
                sh_apaga   <= bus.apaga_zeros;
            end
            carregado <= 1'b1;
            if (tick) begin
                cnt_div <= '0;
                idx     <= fim_quadro ? '0 : idx + 1'b1;
            end else if (bus.habilita) begin
                cnt_div <= cnt_div + 1'b1;
            end
            if (fim_quadro) begin
                cnt_frame <= cnt_frame == FW'(DIV_PISCA - 1) ? '0 : cnt_frame + 1'b1;
                fase      <= cnt_frame == FW'(DIV_PISCA - 1) ? ~fase : fase;
            end
            // tick edge is the inter-digit dead time; the load edge has no valid shadow yet
            if (tick || !bus.habilita || !carregado) begin
                bus.segmentos  <= APAGADO;
                bus.digito_sel <= '1;
            end else begin
                bus.segmentos  <= apagado ? APAGADO : seg_dec;
                bus.digito_sel <= ~(N'(1) << idx);
            end
        end
    end
endmodule

// File: tb/tb_display_7seg_mux.sv
// tb_display_7seg_mux: directed checks of scan, decode, blanking, latch, blink, enable and reset
module tb_display_7seg_mux;
    localparam logic [6:0] OFF = 7'b1111111;
    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
    localparam logic [6:0] SA = 7'b0001000, SB = 7'b0000011, SC = 7'b1000110;
    localparam logic [6:0] SF = 7'b0001110;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vetores = 0;
    int   erros = 0;

    always #5 clk = ~clk;

    display_7seg_mux_if #(.NUM_DIGITOS(4)) bus ();

    display_7seg_mux #(
        .NUM_DIGITOS(4),
        .DIV_VARREDURA(4),
        .DIV_PISCA(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vetores++;
        if (obs !== exp) begin
            erros++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    task automatic chk_saida(input string tag, input logic [3:0] sel, input logic [6:0] seg);
        chk({tag, "_sel"}, 16'(bus.digito_sel), 16'(sel));
        chk({tag, "_seg"}, 16'(bus.segmentos), 16'(seg));
    endtask

    // three lit cycles on digit d, then the dead cycle
    task automatic slot(input string tag, input int d, input logic [6:0] seg);
        logic [3:0] s;
        s = 4'b0001 << d;
        s = ~s;
        for (int k = 0; k < 3; k++) begin
            step;
            chk_saida(tag, s, seg);
        end
        step;
        chk_saida({tag, "_dead"}, 4'hF, OFF);
    endtask

    task automatic quadro(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                          input logic [6:0] e2, input logic [6:0] e3);
        slot({tag, "_d0"}, 0, e0);
        slot({tag, "_d1"}, 1, e1);
        slot({tag, "_d2"}, 2, e2);
        slot({tag, "_d3"}, 3, e3);
    endtask

    // stop at the dead cycle closing the frame, so the next negedge shows digit 0
    task automatic sincroniza(input string tag);
        int n;
        n = 0;
        do begin
            step;
            n++;
        end while (bus.digito_sel !== 4'b0111 && n < 80);
        do begin
            step;
            n++;
        end while (bus.digito_sel !== 4'b1111 && n < 80);
        chk({tag, "_sync"}, 16'(n < 80), 16'd1);
    endtask

    initial begin
        bus.valores     = 16'h1234;
        bus.modo_hex    = 1'b0;
        bus.apaga_zeros = 1'b0;
        bus.pisca       = 4'b0000;
        bus.habilita    = 1'b1;
        #12;
        chk_saida("reset", 4'hF, OFF);
        step;
        rst_n = 1'b1;
        step;
        chk_saida("load_edge", 4'hF, OFF);
        step;
        chk_saida("first_d0", 4'b1110, S4);
        step;
        chk_saida("first_d0b", 4'b1110, S4);
        step;
        chk_saida("first_dead", 4'hF, OFF);
        slot("scan_d1", 1, S3);
        slot("scan_d2", 2, S2);
        slot("scan_d3", 3, S1);
        quadro("scan", S4, S3, S2, S1);

        bus.valores     = 16'h0050;
        bus.apaga_zeros = 1'b1;
        sincroniza("z50");
        quadro("z50", S0, S5, OFF, OFF);
        bus.valores = 16'h0000;
        sincroniza("z00");
        quadro("z00", S0, OFF, OFF, OFF);

        bus.valores     = 16'hABCF;
        bus.apaga_zeros = 1'b0;
        bus.modo_hex    = 1'b1;
        sincroniza("hex1");
        quadro("hex1", SF, SC, SB, SA);
        bus.modo_hex = 1'b0;
        sincroniza("hex0");
        quadro("hex0", OFF, OFF, OFF, OFF);

        bus.valores = 16'h1111;
        sincroniza("latch");
        slot("latch_d0", 0, S1);
        bus.valores = 16'h2222;
        slot("latch_d1", 1, S1);
        slot("latch_d2", 2, S1);
        slot("latch_d3", 3, S1);
        quadro("latch_next", S2, S2, S2, S2);

        bus.valores = 16'h1234;
        sincroniza("hab");
        slot("hab_d0", 0, S4);
        step;
        chk_saida("hab_d1", 4'b1101, S3);
        bus.habilita = 1'b0;
        step;
        chk_saida("hab_off", 4'hF, OFF);
        step;
        step;
        chk_saida("hab_held", 4'hF, OFF);
        bus.habilita = 1'b1;
        step;
        chk_saida("hab_resume", 4'b1101, S3);
        step;
        chk_saida("hab_resume2", 4'b1101, S3);
        step;
        chk_saida("hab_dead", 4'hF, OFF);
        slot("hab_d2", 2, S2);

        step;
        chk_saida("pre_rst", 4'b0111, S1);
        bus.pisca = 4'b0001;
        rst_n = 1'b0;
        #1;
        chk_saida("rst_async", 4'hF, OFF);
        step;
        rst_n = 1'b1;
        step;
        chk_saida("rst_load_edge", 4'hF, OFF);
        step;
        chk_saida("rst_d0", 4'b1110, S4);
        step;
        step;
        chk_saida("rst_dead", 4'hF, OFF);
        slot("blk_f0_d1", 1, S3);
        slot("blk_f0_d2", 2, S2);
        slot("blk_f0_d3", 3, S1);
        quadro("blk_f1", S4, S3, S2, S1);
        quadro("blk_f2", OFF, S3, S2, S1);
        quadro("blk_f3", OFF, S3, S2, S1);
        quadro("blk_f4", S4, S3, S2, S1);

        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, %0d vectors applied", vetores);
        $fatal(1);
    end
endmodule
